// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the next-PC sequencer.
package fetch_pc_ctrl_pkg;

    localparam logic [31:0] START_POINT     = 32'hBFC0_0000;
    localparam int unsigned DEFAULT_PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_SEQ     = 2'd1,
        ST_DS_WAIT = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Redirect inputs and IF-side fetch handshake of the next-PC sequencer.
interface fetch_pc_ctrl_if;
    logic        if_ready;
    logic        exc_req;
    logic [31:0] exc_vec;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_req;
    logic [31:0] br_target;
    logic        br_ds_done;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic        pc_adel;
    logic        flush_o;

    modport master (
        input  if_ready, exc_req, exc_vec, eret_req, epc, br_req, br_target, br_ds_done,
        output pc_valid, pc_out, pc_adel, flush_o
    );

    modport slave (
        output if_ready, exc_req, exc_vec, eret_req, epc, br_req, br_target, br_ds_done,
        input  pc_valid, pc_out, pc_adel, flush_o
    );
endinterface

// File: rtl/fetch_pc_ctrl_redirect_arb.sv
// Combinational priority mux: exception > ERET > branch > sequential.
module fetch_pc_ctrl_redirect_arb (
    input  logic        exc_req,
    input  logic [31:0] exc_vec,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic [31:0] seq_pc,
    output logic [31:0] sel_target,
    output logic        is_flush,
    output logic        is_branch
);

    always_comb begin
        sel_target = seq_pc;
        is_flush   = 1'b0;
        is_branch  = 1'b0;
        if (exc_req) begin
            sel_target = exc_vec;
            is_flush   = 1'b1;
        end else if (eret_req) begin
            sel_target = epc;
            is_flush   = 1'b1;
        end else if (br_req) begin
            sel_target = br_target;
            is_branch  = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Next-PC sequencer: holds the fetch address under the IF handshake and
// defers branch targets until the delay slot has been accepted.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = START_POINT,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    fetch_pc_ctrl_if.master  bus
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  ds_tgt_reg, ds_tgt_next;
    logic         valid_reg, valid_next;
    logic         adel_reg, adel_next;
    logic         flush_reg, flush_next;

    logic [31:0]  seq_pc;
    logic [31:0]  sel_target;
    logic         is_flush;
    logic         is_branch;
    logic         accept;

    assign accept = valid_reg & bus.if_ready;
    assign seq_pc = pc_reg + 32'(PC_STEP);

    fetch_pc_ctrl_redirect_arb u_arb (
        .exc_req    (bus.exc_req),
        .exc_vec    (bus.exc_vec),
        .eret_req   (bus.eret_req),
        .epc        (bus.epc),
        .br_req     (bus.br_req),
        .br_target  (bus.br_target),
        .seq_pc     (seq_pc),
        .sel_target (sel_target),
        .is_flush   (is_flush),
        .is_branch  (is_branch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_BOOT;
            pc_reg     <= RESET_PC;
            ds_tgt_reg <= '0;
            valid_reg  <= 1'b0;
            adel_reg   <= 1'b0;
            flush_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ds_tgt_reg <= ds_tgt_next;
            valid_reg  <= valid_next;
            adel_reg   <= adel_next;
            flush_reg  <= flush_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ds_tgt_next = ds_tgt_reg;
        valid_next  = valid_reg;
        adel_next   = adel_reg;
        flush_next  = 1'b0;

        if (is_flush) begin
            // Exception/ERET override everything, including a deferred branch target.
            pc_next     = sel_target;
            valid_next  = 1'b1;
            adel_next   = is_misaligned(sel_target);
            flush_next  = 1'b1;
            ds_tgt_next = '0;
            state_next  = ST_SEQ;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    pc_next    = RESET_PC;
                    valid_next = 1'b1;
                    adel_next  = is_misaligned(RESET_PC);
                    state_next = ST_SEQ;
                end
                ST_SEQ: begin
                    if (is_branch) begin
                        // Delay slot already gone (or leaving now): issue the target directly.
                        if (bus.br_ds_done || accept || !valid_reg) begin
                            pc_next    = sel_target;
                            valid_next = 1'b1;
                            adel_next  = is_misaligned(sel_target);
                        end else begin
                            ds_tgt_next = sel_target;
                            state_next  = ST_DS_WAIT;
                        end
                    end else if (accept) begin
                        // A misaligned fetch stalls the sequencer until a redirect arrives.
                        if (adel_reg) begin
                            valid_next = 1'b0;
                            adel_next  = 1'b0;
                        end else begin
                            pc_next   = sel_target;
                            adel_next = is_misaligned(sel_target);
                        end
                    end
                end
                ST_DS_WAIT: begin
                    if (accept) begin
                        pc_next    = ds_tgt_reg;
                        adel_next  = is_misaligned(ds_tgt_reg);
                        state_next = ST_SEQ;
                    end
                end
                default: state_next = ST_BOOT;
            endcase
        end
    end

    assign bus.pc_valid = valid_reg;
    assign bus.pc_out   = pc_reg;
    assign bus.pc_adel  = adel_reg;
    assign bus.flush_o  = flush_reg;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; outputs packed as {pc_valid, pc_adel, flush_o, pc_out}.
module tb_fetch_pc_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [34:0] got;
    logic [34:0] e;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] pack_out();
        return {bus.pc_valid, bus.pc_adel, bus.flush_o, bus.pc_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.exc_req    = 1'b0;
        bus.eret_req   = 1'b0;
        bus.br_req     = 1'b0;
        bus.br_ds_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        bus.if_ready  = 1'b1;
        bus.exc_vec   = 32'hBFC0_0380;
        bus.epc       = 32'h0;
        bus.br_target = 32'h0;
        step();
        step();
        rst = 1'b0;
        e = {3'b000, 32'hBFC0_0000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, e); end
        else $display("ok reset_state %h", got);
    endtask

    task automatic test_sequential();
        step();
        e = {3'b100, 32'hBFC0_0000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL boot_valid got=%h exp=%h", got, e); end
        else $display("ok boot_valid %h", got);
        step();
        e = {3'b100, 32'hBFC0_0004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL seq_4 got=%h exp=%h", got, e); end
        else $display("ok seq_4 %h", got);
        step();
        e = {3'b100, 32'hBFC0_0008}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL seq_8 got=%h exp=%h", got, e); end
        else $display("ok seq_8 %h", got);
    endtask

    task automatic test_stall();
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = {3'b100, 32'hBFC0_0008}; total++; got = pack_out();
            if (got !== e) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, got, e); end
            else $display("ok stall_hold%0d %h", i, got);
        end
        bus.if_ready = 1'b1;
        step();
        e = {3'b100, 32'hBFC0_000C}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL stall_resume got=%h exp=%h", got, e); end
        else $display("ok stall_resume %h", got);
        step();
    endtask

    task automatic test_delay_slot();
        // pc_out is BFC00010 here, it is the delay slot
        bus.if_ready = 1'b0; bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h8000_1000;
        step();
        clear_reqs();
        e = {3'b100, 32'hBFC0_0010}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL ds_hold0 got=%h exp=%h", got, e); end
        else $display("ok ds_hold0 %h", got);
        step();
        e = {3'b100, 32'hBFC0_0010}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL ds_hold1 got=%h exp=%h", got, e); end
        else $display("ok ds_hold1 %h", got);
        bus.if_ready = 1'b1;
        step();
        e = {3'b100, 32'h8000_1000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL ds_target got=%h exp=%h", got, e); end
        else $display("ok ds_target %h", got);
        step();
        e = {3'b100, 32'h8000_1004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL ds_after got=%h exp=%h", got, e); end
        else $display("ok ds_after %h", got);
    endtask

    task automatic test_exc_vs_branch();
        bus.exc_req = 1'b1; bus.exc_vec = 32'hBFC0_0380;
        bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h1234_5678;
        step();
        clear_reqs();
        e = {3'b101, 32'hBFC0_0380}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL exc_wins got=%h exp=%h", got, e); end
        else $display("ok exc_wins %h", got);
        step();
        e = {3'b100, 32'hBFC0_0384}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL exc_flush_drop got=%h exp=%h", got, e); end
        else $display("ok exc_flush_drop %h", got);
        step();
        e = {3'b100, 32'hBFC0_0388}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL exc_no_br got=%h exp=%h", got, e); end
        else $display("ok exc_no_br %h", got);
    endtask

    task automatic test_exc_in_ds_wait();
        bus.if_ready = 1'b0; bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h8000_2000;
        step();
        clear_reqs();
        e = {3'b100, 32'hBFC0_0388}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL dsw_enter got=%h exp=%h", got, e); end
        else $display("ok dsw_enter %h", got);
        bus.exc_req = 1'b1;
        step();
        clear_reqs();
        e = {3'b101, 32'hBFC0_0380}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL dsw_exc got=%h exp=%h", got, e); end
        else $display("ok dsw_exc %h", got);
        bus.if_ready = 1'b1;
        step();
        e = {3'b100, 32'hBFC0_0384}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL dsw_tgt_dropped got=%h exp=%h", got, e); end
        else $display("ok dsw_tgt_dropped %h", got);
        step();
    endtask

    task automatic test_eret_wrap();
        bus.eret_req = 1'b1; bus.epc = 32'hFFFF_FFFC;
        step();
        clear_reqs();
        e = {3'b101, 32'hFFFF_FFFC}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL eret_issue got=%h exp=%h", got, e); end
        else $display("ok eret_issue %h", got);
        step();
        e = {3'b100, 32'h0000_0000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL eret_wrap got=%h exp=%h", got, e); end
        else $display("ok eret_wrap %h", got);
        step();
        e = {3'b100, 32'h0000_0004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL eret_after got=%h exp=%h", got, e); end
        else $display("ok eret_after %h", got);
    endtask

    task automatic test_misaligned();
        bus.br_req = 1'b1; bus.br_ds_done = 1'b1; bus.br_target = 32'h8000_0002;
        step();
        clear_reqs();
        e = {3'b110, 32'h8000_0002}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL adel_issue got=%h exp=%h", got, e); end
        else $display("ok adel_issue %h", got);
        for (int i = 0; i < 2; i++) begin
            step();
            e = {3'b000, 32'h8000_0002}; total++; got = pack_out();
            if (got !== e) begin bad++; $display("FAIL adel_stop%0d got=%h exp=%h", i, got, e); end
            else $display("ok adel_stop%0d %h", i, got);
        end
        bus.exc_req = 1'b1; bus.exc_vec = 32'hBFC0_0380;
        step();
        clear_reqs();
        e = {3'b101, 32'hBFC0_0380}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL adel_recover got=%h exp=%h", got, e); end
        else $display("ok adel_recover %h", got);
        step();
        e = {3'b100, 32'hBFC0_0384}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL adel_recover_seq got=%h exp=%h", got, e); end
        else $display("ok adel_recover_seq %h", got);
    endtask

    task automatic test_branch_in_ds();
        bus.if_ready = 1'b0; bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h8000_5000;
        step();
        bus.br_target = 32'h8000_6000;
        step();
        clear_reqs();
        e = {3'b100, 32'hBFC0_0384}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL bid_hold got=%h exp=%h", got, e); end
        else $display("ok bid_hold %h", got);
        bus.if_ready = 1'b1;
        step();
        e = {3'b100, 32'h8000_5000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL bid_first_wins got=%h exp=%h", got, e); end
        else $display("ok bid_first_wins %h", got);
        step();
    endtask

    task automatic test_reset_mid_ds();
        bus.if_ready = 1'b0; bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h8000_3000;
        step();
        clear_reqs();
        e = {3'b100, 32'h8000_5004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL rdsw_enter got=%h exp=%h", got, e); end
        else $display("ok rdsw_enter %h", got);
        #2 rst = 1'b1;
        #1;
        e = {3'b000, 32'hBFC0_0000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL rst_async got=%h exp=%h", got, e); end
        else $display("ok rst_async %h", got);
        step();
        total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL rst_held got=%h exp=%h", got, e); end
        else $display("ok rst_held %h", got);
        rst = 1'b0; bus.if_ready = 1'b1;
        step();
        e = {3'b100, 32'hBFC0_0000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL rst_reboot got=%h exp=%h", got, e); end
        else $display("ok rst_reboot %h", got);
        step();
        e = {3'b100, 32'hBFC0_0004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL rst_tgt_lost got=%h exp=%h", got, e); end
        else $display("ok rst_tgt_lost %h", got);
    endtask

    task automatic test_back_to_back();
        // delay slot accepted in the same cycle as the branch
        bus.br_req = 1'b1; bus.br_ds_done = 1'b0; bus.br_target = 32'h8000_4000;
        step();
        e = {3'b100, 32'h8000_4000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL b2b_accept_ds got=%h exp=%h", got, e); end
        else $display("ok b2b_accept_ds %h", got);
        bus.br_ds_done = 1'b1; bus.br_target = 32'h8000_7000;
        step();
        clear_reqs();
        e = {3'b100, 32'h8000_7000}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got, e); end
        else $display("ok b2b_second %h", got);
        step();
        e = {3'b100, 32'h8000_7004}; total++; got = pack_out();
        if (got !== e) begin bad++; $display("FAIL b2b_seq got=%h exp=%h", got, e); end
        else $display("ok b2b_seq %h", got);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_delay_slot();
        test_exc_vs_branch();
        test_exc_in_ds_wait();
        test_eret_wrap();
        test_misaligned();
        test_branch_in_ds();
        test_reset_mid_ds();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
